// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) arbiter in front of a
// single RAM port. The RAM reports progress through ramstate; a request
// completes on the ACCESS cycle and the matching counter increments.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
// sides are pending. Without it, data always wins over instruction.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
);

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_icount;
  logic [31:0] r_dcount;
  logic        w_dreq;
  logic        w_grant_d;
  logic        w_icomplete;
  logic        w_dcomplete;

  // A write takes precedence over a read when both strobes are high, but
  // either one counts as a pending data request.
  assign w_dreq = dREN | dWEN;

`ifdef ARB_ROUND_ROBIN_EN
  // r_prio_d set: data wins a tie; flipped to the other side on each completion.
  logic r_prio_d;

  // Last-grant pointer: after a data completion instruction is preferred, and vice versa.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_prio_d <= 1'b1;
    end else if (w_dcomplete) begin
      r_prio_d <= 1'b0;
    end else if (w_icomplete) begin
      r_prio_d <= 1'b1;
    end
  end

  assign w_grant_d = w_dreq & (~iREN | r_prio_d);
`else
  assign w_grant_d = w_dreq;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Completion counters, wrapping naturally at 32 bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icount <= '0;
      r_dcount <= '0;
    end else begin
      if (w_icomplete) r_icount <= r_icount + 32'd1;
      if (w_dcomplete) r_dcount <= r_dcount + 32'd1;
    end
  end

  assign icount = r_icount;
  assign dcount = r_dcount;

  // Next-state and RAM/requester outputs; an unserved requester always waits on its own request.
  always_comb begin
    w_next      = r_state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;
    iwait       = iREN;
    dwait       = w_dreq;
    w_icomplete = 1'b0;
    w_dcomplete = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = DSERV;
        end else if (iREN) begin
          w_next = ISERV;
        end
      end
      ISERV: begin
        ramaddr = iaddr;
        if (!iREN) begin
          // Requester gave up: strobe already low, go back without counting.
          w_next = IDLE;
        end else begin
          ramREN = 1'b1;
          case (ramstate)
            RS_ACCESS: begin
              iwait       = 1'b0;
              iload       = ramload;
              w_icomplete = 1'b1;
              w_next      = IDLE;
            end
            RS_ERROR: w_next = IDLE;
            default:  w_next = ISERV;
          endcase
        end
      end
      DSERV: begin
        ramaddr = daddr;
        if (!w_dreq) begin
          w_next = IDLE;
        end else begin
          ramREN = dREN & ~dWEN;
          ramWEN = dWEN;
          if (dWEN) ramstore = dstore;
          case (ramstate)
            RS_ACCESS: begin
              dwait       = 1'b0;
              dload       = ramload;
              w_dcomplete = 1'b1;
              w_next      = IDLE;
            end
            RS_ERROR: w_next = IDLE;
            default:  w_next = DSERV;
          endcase
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vector tables, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;
  logic        iwait, dwait, ramREN, ramWEN;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .icount(icount), .dcount(dcount)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who currently owns the RAM port (0 none, 1 instr, 2 data),
  // completion counts and which side should win a tie.
  int          m_owner;
  logic [31:0] m_icnt, m_dcnt;
  bit          m_pref_d;

  task automatic model_reset();
    m_owner  = 0;
    m_icnt   = 0;
    m_dcnt   = 0;
    m_pref_d = 1'b1;
  endtask

  task automatic model_check();
    logic        dreq, e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    dreq = dREN | dWEN;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    e_iw = iREN; e_dw = dreq;
    if (m_owner == 1) begin
      e_addr = iaddr;
      if (iREN) begin
        e_ren = 1;
        if (ramstate == 2'b10) begin e_iw = 0; e_il = ramload; end
      end
    end else if (m_owner == 2) begin
      e_addr = daddr;
      if (dreq) begin
        e_ren   = dREN & ~dWEN;
        e_wen   = dWEN;
        e_store = dWEN ? dstore : 32'h0;
        if (ramstate == 2'b10) begin e_dw = 0; e_dl = ramload; end
      end
    end
    chk("ramREN", {31'h0, ramREN}, {31'h0, e_ren});
    chk("ramWEN", {31'h0, ramWEN}, {31'h0, e_wen});
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", {31'h0, iwait}, {31'h0, e_iw});
    chk("dwait", {31'h0, dwait}, {31'h0, e_dw});
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("icount", icount, m_icnt);
    chk("dcount", dcount, m_dcnt);
  endtask

  task automatic model_advance();
    logic dreq;
    bit   pref_d;
    dreq = dREN | dWEN;
`ifdef ARB_ROUND_ROBIN_EN
    pref_d = m_pref_d;
`else
    pref_d = 1'b1;
`endif
    if (m_owner == 0) begin
      if (dreq && (!iREN || pref_d)) m_owner = 2;
      else if (iREN)                 m_owner = 1;
    end else if (m_owner == 1) begin
      if (iREN && ramstate == 2'b10) begin m_icnt = m_icnt + 1; m_pref_d = 1'b1; end
      m_owner = (iREN && ramstate < 2'b10) ? 1 : 0;
    end else begin
      if (dreq && ramstate == 2'b10) begin m_dcnt = m_dcnt + 1; m_pref_d = 1'b0; end
      m_owner = (dreq && ramstate < 2'b10) ? 2 : 0;
    end
  endtask

  // One clock: check on the falling edge, then let the model and DUT advance.
  task automatic cycle();
    @(negedge CLK);
    model_check();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    #2;
    model_check();
    @(negedge CLK);
    nRST = 1'b1;
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramstate = 2'b00; ramload = 0;
  endtask

  typedef struct packed {
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore;
    logic [1:0]  rs;
    logic [31:0] rload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_iw, e_dw;
    logic [31:0] e_il, e_dl, e_ic, e_dc;
  } vec_t;

  vec_t tab [10];

  task automatic apply_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      iREN = tab[k].iren; dREN = tab[k].dren; dWEN = tab[k].dwen;
      iaddr = tab[k].iaddr; daddr = tab[k].daddr; dstore = tab[k].dstore;
      ramstate = tab[k].rs; ramload = tab[k].rload;
      @(negedge CLK);
      chk($sformatf("tab%0d.ramREN", k), {31'h0, ramREN}, {31'h0, tab[k].e_ren});
      chk($sformatf("tab%0d.ramWEN", k), {31'h0, ramWEN}, {31'h0, tab[k].e_wen});
      chk($sformatf("tab%0d.ramaddr", k), ramaddr, tab[k].e_addr);
      chk($sformatf("tab%0d.ramstore", k), ramstore, tab[k].e_store);
      chk($sformatf("tab%0d.iwait", k), {31'h0, iwait}, {31'h0, tab[k].e_iw});
      chk($sformatf("tab%0d.dwait", k), {31'h0, dwait}, {31'h0, tab[k].e_dw});
      chk($sformatf("tab%0d.iload", k), iload, tab[k].e_il);
      chk($sformatf("tab%0d.dload", k), dload, tab[k].e_dl);
      chk($sformatf("tab%0d.icount", k), icount, tab[k].e_ic);
      chk($sformatf("tab%0d.dcount", k), dcount, tab[k].e_dc);
      model_advance();
      @(posedge CLK);
      #1;
    end
  endtask

  logic [31:0] grants[$];
  logic [31:0] exp_grant;

  initial begin
    // Instruction read with two BUSY cycles, then a write racing an instruction read.
    tab[0] = '{1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, 2'd0,32'h0,
               1'b0,1'b0, 32'h0,32'h0, 1'b1,1'b0, 32'h0,32'h0, 32'd0,32'd0};
    tab[1] = '{1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, 2'd1,32'h0,
               1'b1,1'b0, 32'h40,32'h0, 1'b1,1'b0, 32'h0,32'h0, 32'd0,32'd0};
    tab[2] = tab[1];
    tab[3] = '{1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, 2'd2,32'h8C220004,
               1'b1,1'b0, 32'h40,32'h0, 1'b0,1'b0, 32'h8C220004,32'h0, 32'd0,32'd0};
    tab[4] = '{1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 2'd0,32'h0,
               1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0, 32'h0,32'h0, 32'd1,32'd0};
    tab[5] = '{1'b1,1'b0,1'b1, 32'h44,32'h100,32'hDEADBEEF, 2'd0,32'h0,
               1'b0,1'b0, 32'h0,32'h0, 1'b1,1'b1, 32'h0,32'h0, 32'd0,32'd0};
    tab[6] = '{1'b1,1'b0,1'b1, 32'h44,32'h100,32'hDEADBEEF, 2'd2,32'h12345678,
               1'b0,1'b1, 32'h100,32'hDEADBEEF, 1'b1,1'b0, 32'h0,32'h12345678, 32'd0,32'd0};
    tab[7] = '{1'b1,1'b0,1'b0, 32'h44,32'h100,32'hDEADBEEF, 2'd0,32'h0,
               1'b0,1'b0, 32'h0,32'h0, 1'b1,1'b0, 32'h0,32'h0, 32'd0,32'd1};
    tab[8] = '{1'b1,1'b0,1'b0, 32'h44,32'h100,32'hDEADBEEF, 2'd2,32'hCAFEF00D,
               1'b1,1'b0, 32'h44,32'h0, 1'b0,1'b0, 32'hCAFEF00D,32'h0, 32'd0,32'd1};
    tab[9] = '{1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 2'd0,32'h0,
               1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0, 32'h0,32'h0, 32'd1,32'd1};

    idle_inputs();
    do_reset();
    apply_rows(0, 4);
    do_reset();
    apply_rows(5, 9);

    // Data read: ERROR forces a retry through IDLE, then a single completion.
    idle_inputs();
    do_reset();
    dREN = 1; daddr = 32'h200;
    cycle();
    ramstate = 2'b11; cycle();
    ramstate = 2'b00; cycle();
    ramstate = 2'b10; ramload = 32'h55AA55AA; cycle();
    dREN = 0; ramstate = 2'b00; cycle();
    chk("err_retry.dcount", dcount, 32'd1);

    // Data read abandoned while BUSY: strobe drops at once, FSM returns to IDLE.
    idle_inputs();
    do_reset();
    dREN = 1; daddr = 32'h300;
    cycle();
    ramstate = 2'b01; cycle();
    dREN = 0;
    #1;
    chk("abandon.ramREN", {31'h0, ramREN}, 32'h0);
    cycle();
    dREN = 1; cycle();
    chk("abandon.dcount", dcount, 32'd0);
    dREN = 0; cycle();

    // Reset pulse in the middle of a BUSY instruction fetch.
    idle_inputs();
    do_reset();
    iREN = 1; iaddr = 32'h80;
    cycle();
    ramstate = 2'b10; cycle();
    ramstate = 2'b01; cycle();
    cycle();
    #2;
    chk("rstmid.ramREN_before", {31'h0, ramREN}, 32'h1);
    nRST = 1'b0;
    model_reset();
    #1;
    chk("rstmid.ramREN", {31'h0, ramREN}, 32'h0);
    chk("rstmid.icount", icount, 32'd0);
    chk("rstmid.iwait", {31'h0, iwait}, 32'h1);
    @(negedge CLK);
    model_check();
    nRST = 1'b1;
    model_advance();
    @(posedge CLK); #1;
    cycle();
    iREN = 0; cycle();

    // Both sides held with immediate ACCESS: record the order of grants.
    idle_inputs();
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h10; daddr = 32'h20;
    ramstate = 2'b10; ramload = 32'h0BADF00D;
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (ramREN) grants.push_back(ramaddr);
      model_check();
      model_advance();
      @(posedge CLK); #1;
    end
    chk("rr.ngrants", grants.size(), 32'd4);
    for (int g = 0; g < 4 && g < grants.size(); g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant = (g % 2 == 0) ? 32'h20 : 32'h10;
`else
      exp_grant = 32'h20;
`endif
      chk($sformatf("rr.grant%0d", g), grants[g], exp_grant);
    end

    // Randomized traffic against the reference model.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) dWEN = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) iaddr = $urandom;
      if ($urandom_range(0, 7) == 0) daddr = $urandom;
      if ($urandom_range(0, 7) == 0) dstore = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      ramload  = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
REQ-002 Ports SHALL be as below; clock is CLK and reset is nRST, asynchronous, active-low:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data
- iwait  out  1  instruction not complete
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dload  out  DATA_W  data read data
- dwait  out  1  data not complete
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM state: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
- icount  out  32  completed instruction transactions
- dcount  out  32  completed data transactions

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISERV, DSERV.
REQ-004 In IDLE, the block SHALL drive no RAM strobes and SHALL hold iwait = iREN and dwait = (dREN|dWEN).
REQ-005 In IDLE, a pending data request SHALL move to DSERV; otherwise a pending iREN SHALL move to ISERV; the transition happens on the next CLK edge.
REQ-006 When dREN and dWEN are both high, the block SHALL treat the request as a write; dREN is ignored.
REQ-007 In ISERV, ramREN SHALL be 1, ramWEN 0, ramaddr = iaddr, and dwait = (dREN|dWEN).
REQ-008 In DSERV, ramREN SHALL equal dREN & ~dWEN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore, and iwait = iREN.
REQ-009 In the serving state, while ramstate == ACCESS, the served wait output SHALL be 0 and iload or dload SHALL equal ramload combinationally.
REQ-010 On that ACCESS cycle, the FSM SHALL return to IDLE and the matching counter SHALL increment by 1; counters wrap from 0xFFFFFFFF to 0.
REQ-011 While serving, ramstate FREE or BUSY SHALL hold the state, with the served wait = 1.
REQ-012 While serving, ramstate ERROR SHALL return the FSM to IDLE with the served wait = 1 and no count increment, so the request is retried.
REQ-013 If the served requester deasserts its request mid-transaction, RAM strobes SHALL drop in that same cycle and the FSM SHALL return to IDLE next cycle with no count increment.
REQ-014 A grant SHALL never change between requesters without passing through IDLE.
REQ-015 The minimum latency SHALL be 2 cycles from request to wait low: one IDLE cycle, then ACCESS in the first serving cycle.
REQ-016 Outside the served requester, iload and dload SHALL be 0.
REQ-017 When not writing, ramstore SHALL be 0.

Reset
REQ-018 nRST low SHALL asynchronously force state IDLE, icount = 0, dcount = 0, and the round-robin pointer to the data side.
REQ-019 An assertion of nRST mid-transaction SHALL abort the transaction with no completion reported.
REQ-020 During reset, ramREN and ramWEN SHALL be 0, and iwait and dwait SHALL follow the IDLE rule.

Configuration
REQ-021 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-022 With ARB_ROUND_ROBIN_EN undefined, priority SHALL be fixed data-first per REQ-005.
REQ-023 With ARB_ROUND_ROBIN_EN defined, a 1-bit last-grant register SHALL be updated on every completion.
REQ-024 With ARB_ROUND_ROBIN_EN defined, when both requesters are pending in IDLE, the side not last granted SHALL win.
REQ-025 With ARB_ROUND_ROBIN_EN defined, a single pending requester SHALL always win.

Verification
REQ-026 The bench SHALL cover: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40, iwait low exactly on the ACCESS cycle, iload=0x8C220004, icount=1.
REQ-027 The bench SHALL cover: iREN=1 and dWEN=1 same cycle, daddr=0x100, dstore=0xDEADBEEF -> DSERV first, ramWEN=1, ramstore=0xDEADBEEF; ISERV follows; dcount=1 before icount=1.
REQ-028 The bench SHALL cover: dREN held in DSERV, ramstate ERROR once then ACCESS -> return to IDLE, re-enter DSERV, single completion, dcount=1.
REQ-029 The bench SHALL cover: dREN dropped while BUSY in DSERV -> ramREN=0 that cycle, IDLE next, dcount unchanged.
REQ-030 The bench SHALL cover: nRST pulsed low in ISERV while BUSY -> ramREN=0 immediately, icount=0, state IDLE.
REQ-031 The bench SHALL cover: with ARB_ROUND_ROBIN_EN, iREN and dREN held continuously with ACCESS every serving cycle -> grants alternate D,I,D,I; without it, only D is served.
